tx_pybuf_reader: RTL and testbench
==================================

Name: tx_pybuf_reader

Overview:
- Transmit-side counterpart of the payload receive path (header decoder plus 32-bit word packer into the RX payload RAM).
- Reads 32-bit words from the TX payload RAM, prepends the payload header, and serializes bits LSB-first onto bufpacketin.
- The payload bit processor consumes bufpacketin one bit per bit-advance pulse, ahead of CRC/FEC/whitening.
- Uses a one-word prefetch so the serial stream never stalls on RAM latency.

Parameters:
- MAXBYTE, 1021, saturation limit on payload byte count (matches the receive-side clamp).
- ADRW, 8, TX RAM word-address width.

Ports:
- clk_6M  input  1  6 MHz system clock
- rstz  input  1  asynchronous active-low reset
- py_st_p  input  1  payload start pulse; restarts the block
- bit_adv_p  input  1  current bit consumed (py_datvalid_p & daten & py_datperiod); advance to next bit
- py_abort_p  input  1  abort pulse (e.g. tx py_endp or slot kill); return to IDLE
- existpyheader  input  1  packet carries a payload header
- BRss  input  1  1 = 8-bit header with 5-bit length; 0 = 16-bit header with 10-bit length
- regi_LLID  input  2  header LLID
- regi_FLOW  input  1  header FLOW bit
- regi_pylenByte  input  10  payload data length in bytes
- txpydout  input  32  TX RAM read data; valid the cycle after txpyrd_p
- txpyadr  output  ADRW  TX RAM word address
- txpyrd_p  output  1  one-cycle RAM read strobe
- bufpacketin  output  1  current payload bit, combinational from state
- tx_busy  output  1  high in HDR or DATA
- tx_underrun  output  1  sticky; set when a data bit is consumed but no word is loaded
- tx_done  output  1  high in DONE

Behaviour:
- Reset: txpyadr=0, txpyrd_p=0, bufpacketin=0, tx_busy=0, tx_underrun=0, tx_done=0, state IDLE, all shift registers and valid flags 0.
- Sampling at py_st_p:
  - len = min(regi_pylenByte, MAXBYTE). When BRss=1, len = regi_pylenByte[4:0].
  - Data bits = len*8. Words needed = ceil(len/4).
- Header shift register, transmitted LSB-first:
  - BRss=1: {len[4:0], FLOW, LLID[1:0]} gives 8 bits, LLID[0] first.
  - BRss=0: {3'b000, len[9:0], FLOW, LLID[1:0]} gives 16 bits.
- FSM states: IDLE, HDR, DATA, DONE.
  - IDLE --py_st_p--> HDR if existpyheader, else DATA.
  - If existpyheader=1 and len=0: HDR --last header bit advanced--> DONE.
  - Otherwise: HDR --last header bit advanced--> DATA.
  - DATA --last data bit (bit index len*8-1) advanced--> DONE.
  - DATA with len=0 and no header: enters DONE on the cycle after py_st_p.
  - DONE --py_st_p--> restart. Otherwise DONE holds; bufpacketin=0.
  - Any state --py_abort_p--> IDLE; prefetch valid flag and read tracking are cleared.
  - py_st_p has priority over py_abort_p, which has priority over bit_adv_p.
- Fetch pipeline:
  - py_st_p sets txpyadr=0 and issues txpyrd_p on the following cycle, if words needed > 0.
  - The word is captured into the prefetch register one cycle after txpyrd_p; prefetch valid is then set.
  - When the data shift register is empty and prefetch is valid, the prefetch moves into the shift register in that same cycle, resetting the 5-bit bit index.
  - After each move: txpyadr increments, and a new read is issued if words read < words needed.
  - A word move and a bit_adv_p on bit 31 in the same cycle is seamless: the next bit comes from the new word.
  - At most one outstanding read at a time. No read is issued beyond words needed.
- Bit output:
  - HDR: header shift register bit 0.
  - DATA: data shift register bit 0 when loaded; 0 when empty.
  - On bit_adv_p, the active register shifts right and the bit index increments; bit index 31 → empty.
- Underrun:
  - bit_adv_p in DATA with the shift register empty sets tx_underrun, which stays set until py_st_p.
  - The bit still counts toward len*8, with bufpacketin=0 for that bit.
- Partial last word: only the low (len*8 mod 32) bits are used; the rest are discarded.
- bit_adv_p in IDLE or DONE is ignored.

Test Plan:
- BRss=1, existpyheader=1, LLID=2'b10, FLOW=1, len=5, RAM word0=32'h03020100, word1=32'h04 -> header bits 0,1,1,1,0,1,0,0; then 40 data bits 0x00,0x01,0x02,0x03,0x04 LSB-first; exactly 2 reads (adr 0,1); tx_done after bit 48.
- BRss=0, LLID=1, FLOW=0, len=1021 (regi_pylenByte=1023), bit_adv_p every 6 cycles -> 16-bit header encoding length 1021; 256 reads; adr wraps 255→0 only after the last read; data matches RAM; tx_underrun=0.
- existpyheader=0, len=4, bit_adv_p in consecutive cycles from cycle 3 after py_st_p -> first bits underrun (tx_underrun=1, bufpacketin=0); total 32 bits counted; DONE reached.
- py_abort_p mid-DATA at bit 17 -> IDLE, tx_busy=0, no further txpyrd_p; a subsequent py_st_p restarts from adr 0 with a clean stream.
- py_st_p coincident with bit_adv_p and py_abort_p while in DONE -> restart wins; header bit 0 presented; tx_underrun cleared.
- existpyheader=1, len=0 -> 8 header bits, then DONE; zero txpyrd_p pulses.

Source files
------------

// File: rtl/tx_pybuf_reader.sv
// rtl/tx_pybuf_reader.sv - TX payload reader: prepends the payload header, prefetches
// 32-bit words from the TX payload RAM and serializes them LSB-first onto bufpacketin.
module tx_pybuf_reader #(
  parameter int MAXBYTE = 1021,
  parameter int ADRW    = 8
) (
  input  logic            clk_6M,
  input  logic            rstz,
  input  logic            py_st_p,
  input  logic            bit_adv_p,
  input  logic            py_abort_p,
  input  logic            existpyheader,
  input  logic            BRss,
  input  logic [1:0]      regi_LLID,
  input  logic            regi_FLOW,
  input  logic [9:0]      regi_pylenByte,
  input  logic [31:0]     txpydout,
  output logic [ADRW-1:0] txpyadr,
  output logic            txpyrd_p,
  output logic            bufpacketin,
  output logic            tx_busy,
  output logic            tx_underrun,
  output logic            tx_done
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t      state;
  logic [15:0] hdr_sr;
  logic [3:0]  hdr_idx;
  logic        hdr_short;
  logic [9:0]  len_r;
  logic [8:0]  need;
  logic [8:0]  rd_cnt;
  logic [12:0] data_cnt;
  logic [31:0] data_sr;
  logic        data_vld;
  logic [4:0]  bit_idx;
  logic [31:0] pf_word;
  logic        pf_vld;
  logic        rd_d1;

  logic [9:0]  len_clamp;
  logic [10:0] need_sum;
  logic [8:0]  need_start;
  logic [15:0] hdr_init;
  logic [12:0] data_last;
  logic        hdr_last;
  logic        data_adv;
  logic        move;

  always_comb begin
    len_clamp = regi_pylenByte;
    if (BRss)
      len_clamp = {5'd0, regi_pylenByte[4:0]};
    else if (regi_pylenByte > 10'(MAXBYTE))
      len_clamp = 10'(MAXBYTE);
  end

  assign need_sum   = {1'b0, len_clamp} + 11'd3;
  assign need_start = need_sum[10:2];
  assign hdr_init   = BRss ? {8'd0, len_clamp[4:0], regi_FLOW, regi_LLID}
                           : {3'b000, len_clamp, regi_FLOW, regi_LLID};
  assign data_last  = {len_r, 3'b000} - 13'd1;
  assign hdr_last   = (hdr_idx == (hdr_short ? 4'd7 : 4'd15));
  assign data_adv   = bit_adv_p && (state == DATA);

  // Refill the shifter when empty, or exactly when its last bit is consumed so the stream never gaps.
  assign move = pf_vld && ((state == HDR) || (state == DATA)) &&
                (!data_vld || (data_adv && (bit_idx == 5'd31)));

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state       <= IDLE;
      hdr_sr      <= '0;
      hdr_idx     <= '0;
      hdr_short   <= 1'b0;
      len_r       <= '0;
      need        <= '0;
      rd_cnt      <= '0;
      data_cnt    <= '0;
      data_sr     <= '0;
      data_vld    <= 1'b0;
      bit_idx     <= '0;
      pf_word     <= '0;
      pf_vld      <= 1'b0;
      rd_d1       <= 1'b0;
      txpyadr     <= '0;
      txpyrd_p    <= 1'b0;
      tx_underrun <= 1'b0;
    end else if (py_st_p) begin
      state       <= existpyheader ? HDR : DATA;
      hdr_sr      <= hdr_init;
      hdr_idx     <= '0;
      hdr_short   <= BRss;
      len_r       <= len_clamp;
      need        <= need_start;
      rd_cnt      <= (need_start != 9'd0) ? 9'd1 : 9'd0;
      txpyrd_p    <= (need_start != 9'd0);
      txpyadr     <= '0;
      data_cnt    <= '0;
      data_vld    <= 1'b0;
      bit_idx     <= '0;
      pf_vld      <= 1'b0;
      rd_d1       <= 1'b0;
      tx_underrun <= 1'b0;
    end else if (py_abort_p) begin
      state    <= IDLE;
      txpyrd_p <= 1'b0;
      rd_d1    <= 1'b0;
      pf_vld   <= 1'b0;
      data_vld <= 1'b0;
    end else begin
      rd_d1    <= txpyrd_p;
      txpyrd_p <= 1'b0;

      if (move) begin
        data_sr  <= pf_word;
        data_vld <= 1'b1;
        bit_idx  <= '0;
        pf_vld   <= 1'b0;
        txpyadr  <= txpyadr + ADRW'(1);
        if (rd_cnt < need) begin
          txpyrd_p <= 1'b1;
          rd_cnt   <= rd_cnt + 9'd1;
        end
      end else if (data_adv && data_vld) begin
        data_sr <= data_sr >> 1;
        bit_idx <= bit_idx + 5'd1;
        if (bit_idx == 5'd31)
          data_vld <= 1'b0;
      end

      // RAM data lands one cycle after the strobe; at most one read is ever in flight.
      if (rd_d1) begin
        pf_word <= txpydout;
        pf_vld  <= 1'b1;
      end

      case (state)
        HDR: begin
          if (bit_adv_p) begin
            hdr_sr  <= hdr_sr >> 1;
            hdr_idx <= hdr_idx + 4'd1;
            if (hdr_last)
              state <= (len_r == 10'd0) ? DONE : DATA;
          end
        end
        DATA: begin
          if (len_r == 10'd0) begin
            state <= DONE;
          end else if (bit_adv_p) begin
            data_cnt <= data_cnt + 13'd1;
            if (!data_vld)
              tx_underrun <= 1'b1;
            if (data_cnt == data_last)
              state <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bufpacketin = 1'b0;
    if (state == HDR)
      bufpacketin = hdr_sr[0];
    else if ((state == DATA) && data_vld)
      bufpacketin = data_sr[0];
  end

  assign tx_busy = (state == HDR) || (state == DATA);
  assign tx_done = (state == DONE);

endmodule

// File: tb/tb_tx_pybuf_reader.sv
// tb/tb_tx_pybuf_reader.sv - self-checking bench for tx_pybuf_reader: vector table,
// bit scoreboard, RAM model, plus abort and restart-priority sequences.
module tb_tx_pybuf_reader;

  logic        clk_6M;
  logic        rstz;
  logic        py_st_p;
  logic        bit_adv_p;
  logic        py_abort_p;
  logic        existpyheader;
  logic        BRss;
  logic [1:0]  regi_LLID;
  logic        regi_FLOW;
  logic [9:0]  regi_pylenByte;
  logic [31:0] txpydout;
  logic [7:0]  txpyadr;
  logic        txpyrd_p;
  logic        bufpacketin;
  logic        tx_busy;
  logic        tx_underrun;
  logic        tx_done;

  tx_pybuf_reader #(.MAXBYTE(1021), .ADRW(8)) dut (
    .clk_6M        (clk_6M),
    .rstz          (rstz),
    .py_st_p       (py_st_p),
    .bit_adv_p     (bit_adv_p),
    .py_abort_p    (py_abort_p),
    .existpyheader (existpyheader),
    .BRss          (BRss),
    .regi_LLID     (regi_LLID),
    .regi_FLOW     (regi_FLOW),
    .regi_pylenByte(regi_pylenByte),
    .txpydout      (txpydout),
    .txpyadr       (txpyadr),
    .txpyrd_p      (txpyrd_p),
    .bufpacketin   (bufpacketin),
    .tx_busy       (tx_busy),
    .tx_underrun   (tx_underrun),
    .tx_done       (tx_done)
  );

  initial clk_6M = 1'b0;
  always #5 clk_6M = ~clk_6M;

  logic [31:0] mem [0:255];
  always_ff @(posedge clk_6M) begin
    if (txpyrd_p)
      txpydout <= mem[txpyadr];
  end

  typedef struct {
    bit       brss;
    bit       hdr;
    bit [1:0] llid;
    bit       flow;
    bit [9:0] len_in;
    bit [9:0] exp_len;
    int       gap;
    int       start;
    int       reads;
    int       und;
    bit       exp_und;
  } vec_t;

  vec_t vecs [5];
  bit   sb [$];
  int   n_cmp;
  int   n_fail;
  int   rd_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk_6M);
    if (txpyrd_p) begin
      check("rd_adr", 32'(txpyadr), 32'(rd_cnt[7:0]));
      rd_cnt++;
    end
    if (bit_adv_p && !py_st_p && !py_abort_p && (sb.size() > 0)) begin
      bit e;
      e = sb.pop_front();
      check("bit", 32'(bufpacketin), 32'(e));
    end
    @(posedge clk_6M);
    #1;
  endtask

  task automatic build_exp(input vec_t v);
    logic [15:0] h;
    int          nh;
    sb.delete();
    if (v.hdr) begin
      if (v.brss) begin
        h  = {8'd0, v.exp_len[4:0], v.flow, v.llid};
        nh = 8;
      end else begin
        h  = {3'b000, v.exp_len, v.flow, v.llid};
        nh = 16;
      end
      for (int i = 0; i < nh; i++) sb.push_back(h[i]);
    end
    for (int k = 0; k < int'(v.exp_len) * 8; k++) begin
      if (k < v.und) begin
        sb.push_back(1'b0);
      end else begin
        int          b;
        logic [31:0] w;
        b = k - v.und;
        w = mem[b / 32];
        sb.push_back(w[b % 32]);
      end
    end
  endtask

  task automatic run_packet(input vec_t v, input bit coinc, input int abort_at);
    int nbits;
    existpyheader  = v.hdr;
    BRss           = v.brss;
    regi_LLID      = v.llid;
    regi_FLOW      = v.flow;
    regi_pylenByte = v.len_in;
    build_exp(v);
    nbits  = sb.size();
    rd_cnt = 0;
    py_st_p = 1'b1;
    if (coinc) begin
      bit_adv_p  = 1'b1;
      py_abort_p = 1'b1;
    end
    cyc();
    py_st_p    = 1'b0;
    bit_adv_p  = 1'b0;
    py_abort_p = 1'b0;
    if (coinc) begin
      check("restart_busy", 32'(tx_busy), 32'd1);
      check("restart_underrun", 32'(tx_underrun), 32'd0);
      check("restart_bit0", 32'(bufpacketin), 32'(sb[0]));
    end
    repeat (v.start - 1) cyc();
    for (int k = 0; k < nbits; k++) begin
      if (k == abort_at) begin
        py_abort_p = 1'b1;
        cyc();
        py_abort_p = 1'b0;
        sb.delete();
        check("abort_busy", 32'(tx_busy), 32'd0);
        for (int j = 0; j < 40; j++) begin
          bit_adv_p = j[0];
          cyc();
        end
        bit_adv_p = 1'b0;
        check("abort_reads", 32'(rd_cnt), 32'd2);
        check("abort_idle_done", 32'(tx_done), 32'd0);
        check("abort_idle_busy", 32'(tx_busy), 32'd0);
        return;
      end
      bit_adv_p = 1'b1;
      cyc();
      bit_adv_p = 1'b0;
      repeat (v.gap - 1) cyc();
    end
    check("done", 32'(tx_done), 32'd1);
    check("busy_end", 32'(tx_busy), 32'd0);
    check("reads", 32'(rd_cnt), 32'(v.reads));
    check("adr_end", 32'(txpyadr), 32'(v.reads[7:0]));
    check("underrun", 32'(tx_underrun), 32'(v.exp_und));
    check("sb_left", 32'(sb.size()), 32'd0);
    check("done_out", 32'(bufpacketin), 32'd0);
    repeat (3) cyc();
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 1'b1, 2'b10, 1'b1, 10'd5,     10'd5,    1, 1, 2,   0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 2'b01, 1'b0, 10'd1023,  10'd1021, 6, 1, 256, 0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 2'b01, 1'b1, 10'd0,     10'd0,    1, 1, 0,   0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 2'b11, 1'b0, 10'h327,   10'd7,    1, 5, 2,   0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 2'b00, 1'b1, 10'd4,     10'd4,    1, 3, 1,   1, 1'b1};

    for (int i = 0; i < 256; i++)
      mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};

    n_cmp = 0; n_fail = 0; rd_cnt = 0;
    rstz = 1'b0; py_st_p = 1'b0; bit_adv_p = 1'b0; py_abort_p = 1'b0;
    existpyheader = 1'b0; BRss = 1'b0; regi_LLID = 2'b00; regi_FLOW = 1'b0;
    regi_pylenByte = 10'd0;

    repeat (3) @(posedge clk_6M);
    #1;
    check("rst_adr", 32'(txpyadr), 32'd0);
    check("rst_rd", 32'(txpyrd_p), 32'd0);
    check("rst_bit", 32'(bufpacketin), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_underrun", 32'(tx_underrun), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    rstz = 1'b1;
    repeat (2) cyc();

    for (int i = 0; i < 5; i++) run_packet(vecs[i], 1'b0, -1);

    // DONE with underrun set: start+abort+advance together must restart cleanly.
    v      = vecs[0];
    v.llid = 2'b11;
    run_packet(v, 1'b1, -1);

    v = '{1'b0, 1'b0, 2'b00, 1'b0, 10'd16, 10'd16, 1, 5, 4, 0, 1'b0};
    run_packet(v, 1'b0, 17);
    run_packet(v, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
